// File: rtl/vec_mem_sequencer.sv
// Address/enable sequencer for one vector operation: issues operand-read pairs
// to the 2R1W memory and, RD_LAT cycles later, the matching result writes.
module vec_mem_sequencer #(
  parameter int ADDR_W = 13,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  numberofv,
  input  logic [ADDR_W-1:0] src_addr_a,
  input  logic [ADDR_W-1:0] src_addr_b,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  output logic              fe,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [RD_LAT-1:0] LAST_STAGE = RD_LAT'(1) << (RD_LAT - 1);

  logic [1:0]        state, next_state;
  logic [CNT_W-1:0]  n, idx;
  logic [ADDR_W-1:0] base_a, base_b, base_d;
  logic [RD_LAT-1:0] pipe_v;
  logic [ADDR_W-1:0] pipe_a [RD_LAT];
  logic              drain_empty;

  // The last stage is retiring this cycle, so only the younger stages matter.
  assign drain_empty = (pipe_v & ~LAST_STAGE) == '0;

  assign busy      = state != ST_IDLE;
  assign done      = state == ST_DONE;
  assign rd_en     = (state == ST_ISSUE) && !stall;
  assign fe        = rd_en && (idx == '0);
  assign rd_addr_a = base_a + ADDR_W'(idx);
  assign rd_addr_b = base_b + ADDR_W'(idx);
  assign wr_en     = pipe_v[RD_LAT-1];
  assign wr_addr   = pipe_a[RD_LAT-1];

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (start) next_state = (numberofv == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (rd_en && idx == n - CNT_W'(1)) next_state = ST_DRAIN;
      ST_DRAIN: if (drain_empty) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      n      <= '0;
      idx    <= '0;
      base_a <= '0;
      base_b <= '0;
      base_d <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && start) begin
        n      <= numberofv;
        idx    <= '0;
        base_a <= src_addr_a;
        base_b <= src_addr_b;
        base_d <= dst_addr;
      end else if (rd_en) begin
        idx <= idx + CNT_W'(1);
      end
    end
  end

  // Latency pipe shifts every cycle regardless of state or stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= rd_en;
      pipe_a[0] <= rd_en ? base_d + ADDR_W'(idx) : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed cycle-by-cycle bench for vec_mem_sequencer at default parameters.
module tb_vec_mem_sequencer;

  localparam int ADDR_W = 13;
  localparam int CNT_W  = 8;
  localparam int RD_LAT = 2;
  localparam int MAXC   = 300;

  logic              clock = 1'b0;
  logic              reset, start, stall;
  logic [CNT_W-1:0]  numberofv;
  logic [ADDR_W-1:0] src_addr_a, src_addr_b, dst_addr;
  logic              busy, done, rd_en, fe, wr_en;
  logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr;

  always #5 clock = ~clock;

  vec_mem_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .numberofv(numberofv),
    .src_addr_a(src_addr_a), .src_addr_b(src_addr_b), .dst_addr(dst_addr),
    .stall(stall), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .fe(fe),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  int total = 0;
  int bad   = 0;
  int rdCount, wrCount, switchAt;

  logic expRd [MAXC], expFe [MAXC], expWr [MAXC], expDone [MAXC];
  logic expBusy [MAXC], expZero [MAXC];
  logic inStart [MAXC], inStall [MAXC], inReset [MAXC];
  logic [ADDR_W-1:0] expA [MAXC], expB [MAXC], expW [MAXC];
  logic [CNT_W-1:0]  n1, n2;
  logic [ADDR_W-1:0] a1, b1, d1, a2, b2, d2;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearVectors();
    for (int i = 0; i < MAXC; i++) begin
      expRd[i] = 0; expFe[i] = 0; expWr[i] = 0; expDone[i] = 0;
      expBusy[i] = 0; expZero[i] = 0;
      inStart[i] = 0; inStall[i] = 0; inReset[i] = 0;
      expA[i] = '0; expB[i] = '0; expW[i] = '0;
    end
    switchAt = MAXC;
    rdCount = 0;
    wrCount = 0;
  endtask

  task automatic expectRead(input int c, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W-1:0] b, input logic f);
    expRd[c] = 1; expA[c] = a; expB[c] = b; expFe[c] = f;
  endtask

  task automatic expectWrite(input int c, input logic [ADDR_W-1:0] w);
    expWr[c] = 1; expW[c] = w;
  endtask

  task automatic expectBusy(input int from, input int to);
    for (int i = from; i <= to; i++) expBusy[i] = 1;
  endtask

  // Drives one cycle per vector entry; cycle 0 is the cycle whose closing edge samples start.
  task automatic applyStimulus(input string name, input int len);
    for (int c = 0; c < len; c++) begin
      reset = inReset[c];
      start = inStart[c];
      stall = inStall[c];
      if (c >= switchAt) begin
        numberofv = n2; src_addr_a = a2; src_addr_b = b2; dst_addr = d2;
      end else begin
        numberofv = n1; src_addr_a = a1; src_addr_b = b1; dst_addr = d1;
      end
      @(negedge clock);
      checkOutput($sformatf("%s.rd_en@%0d", name, c), 32'(rd_en), 32'(expRd[c]));
      checkOutput($sformatf("%s.fe@%0d", name, c), 32'(fe), 32'(expFe[c]));
      checkOutput($sformatf("%s.wr_en@%0d", name, c), 32'(wr_en), 32'(expWr[c]));
      checkOutput($sformatf("%s.done@%0d", name, c), 32'(done), 32'(expDone[c]));
      checkOutput($sformatf("%s.busy@%0d", name, c), 32'(busy), 32'(expBusy[c]));
      if (expRd[c]) begin
        checkOutput($sformatf("%s.rd_addr_a@%0d", name, c), 32'(rd_addr_a), 32'(expA[c]));
        checkOutput($sformatf("%s.rd_addr_b@%0d", name, c), 32'(rd_addr_b), 32'(expB[c]));
      end
      if (expWr[c])
        checkOutput($sformatf("%s.wr_addr@%0d", name, c), 32'(wr_addr), 32'(expW[c]));
      if (expZero[c]) begin
        checkOutput($sformatf("%s.zero_a@%0d", name, c), 32'(rd_addr_a), 32'd0);
        checkOutput($sformatf("%s.zero_b@%0d", name, c), 32'(rd_addr_b), 32'd0);
        checkOutput($sformatf("%s.zero_w@%0d", name, c), 32'(wr_addr), 32'd0);
      end
      if (rd_en === 1'b1) rdCount++;
      if (wr_en === 1'b1) wrCount++;
      @(posedge clock);
      #1;
    end
    reset = 0; start = 0; stall = 0;
  endtask

  initial begin
    reset = 1; start = 0; stall = 0; numberofv = '0;
    src_addr_a = '0; src_addr_b = '0; dst_addr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.rd_en", 32'(rd_en), 32'd0);
    checkOutput("reset.fe", 32'(fe), 32'd0);
    checkOutput("reset.wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset.rd_addr_a", 32'(rd_addr_a), 32'd0);
    checkOutput("reset.rd_addr_b", 32'(rd_addr_b), 32'd0);
    checkOutput("reset.wr_addr", 32'(wr_addr), 32'd0);
    @(posedge clock);
    #1;
    reset = 0;

    $display("[TB] basic run");
    clearVectors();
    n1 = 8'd4; a1 = 13'h010; b1 = 13'h100; d1 = 13'h200;
    inStart[0] = 1;
    for (int k = 0; k < 4; k++) begin
      expectRead(1 + k, 13'h010 + ADDR_W'(k), 13'h100 + ADDR_W'(k), k == 0);
      expectWrite(3 + k, 13'h200 + ADDR_W'(k));
    end
    expDone[7] = 1;
    expectBusy(1, 7);
    applyStimulus("basic", 10);

    $display("[TB] stall");
    clearVectors();
    n1 = 8'd3; a1 = 13'h020; b1 = 13'h040; d1 = 13'h060;
    inStart[0] = 1;
    inStall[2] = 1; inStall[3] = 1; inStall[7] = 1; inStall[9] = 1;
    expectRead(1, 13'h020, 13'h040, 1);
    expectRead(4, 13'h021, 13'h041, 0);
    expectRead(5, 13'h022, 13'h042, 0);
    expectWrite(3, 13'h060);
    expectWrite(6, 13'h061);
    expectWrite(7, 13'h062);
    expDone[8] = 1;
    expectBusy(1, 8);
    applyStimulus("stall", 11);

    $display("[TB] zero count");
    clearVectors();
    n1 = 8'd0; a1 = 13'h111; b1 = 13'h222; d1 = 13'h333;
    inStart[0] = 1;
    expDone[1] = 1;
    expectBusy(1, 1);
    applyStimulus("zero", 5);

    $display("[TB] max count");
    clearVectors();
    n1 = 8'd255; a1 = 13'h000; b1 = 13'h1000; d1 = 13'h0800;
    inStart[0] = 1;
    for (int k = 0; k < 255; k++) begin
      expectRead(1 + k, ADDR_W'(k), 13'h1000 + ADDR_W'(k), k == 0);
      expectWrite(3 + k, 13'h0800 + ADDR_W'(k));
    end
    expDone[258] = 1;
    expectBusy(1, 258);
    applyStimulus("max", 261);
    checkOutput("max.rd_count", 32'(rdCount), 32'd255);
    checkOutput("max.wr_count", 32'(wrCount), 32'd255);

    $display("[TB] address wrap");
    clearVectors();
    n1 = 8'd4; a1 = 13'h1FFE; b1 = 13'h0005; d1 = 13'h1FFD;
    inStart[0] = 1;
    expectRead(1, 13'h1FFE, 13'h0005, 1);
    expectRead(2, 13'h1FFF, 13'h0006, 0);
    expectRead(3, 13'h0000, 13'h0007, 0);
    expectRead(4, 13'h0001, 13'h0008, 0);
    expectWrite(3, 13'h1FFD);
    expectWrite(4, 13'h1FFE);
    expectWrite(5, 13'h1FFF);
    expectWrite(6, 13'h0000);
    expDone[7] = 1;
    expectBusy(1, 7);
    applyStimulus("wrap", 9);

    $display("[TB] reset mid-op");
    clearVectors();
    n1 = 8'd8; a1 = 13'h030; b1 = 13'h050; d1 = 13'h070;
    inStart[0] = 1;
    inReset[5] = 1;
    for (int k = 0; k < 5; k++) expectRead(1 + k, 13'h030 + ADDR_W'(k), 13'h050 + ADDR_W'(k), k == 0);
    for (int k = 0; k < 3; k++) expectWrite(3 + k, 13'h070 + ADDR_W'(k));
    expectBusy(1, 5);
    expZero[6] = 1;
    applyStimulus("rstmid", 14);

    $display("[TB] ignored start");
    clearVectors();
    n1 = 8'd2; a1 = 13'h100; b1 = 13'h200; d1 = 13'h300;
    n2 = 8'd1; a2 = 13'h400; b2 = 13'h500; d2 = 13'h600;
    switchAt = 1;
    inStart[0] = 1; inStart[1] = 1; inStart[5] = 1; inStart[6] = 1;
    expectRead(1, 13'h100, 13'h200, 1);
    expectRead(2, 13'h101, 13'h201, 0);
    expectWrite(3, 13'h300);
    expectWrite(4, 13'h301);
    expDone[5] = 1;
    expectBusy(1, 5);
    expectRead(7, 13'h400, 13'h500, 1);
    expectWrite(9, 13'h600);
    expDone[10] = 1;
    expectBusy(7, 10);
    applyStimulus("restart", 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
- Sequences one vector operation over the shared memory datapath.
- On `start`, it issues `numberofv` operand-read pairs to the 2R1W operand memory, with one pair per cycle unless stalled.
- After a fixed read/compute latency, it writes each result into the 1R1W result memory.
- Sits between the top-level command interface and the memory/ALU datapath. It generates addresses, read and write enables, and the first-element flag; it carries no data.

Parameters:
- ADDR_W, 13, address width of both memories; all address arithmetic is modulo 2^ADDR_W.
- CNT_W, 8, width of the element count.
- RD_LAT, 2, cycles from `rd_en` to the matching `wr_en`. Legal range is 1 to 8.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- numberofv  in  CNT_W  element count; 0 is legal and means no-op.
- src_addr_a  in  ADDR_W  base address of operand A.
- src_addr_b  in  ADDR_W  base address of operand B.
- dst_addr  in  ADDR_W  base address of the result.
- stall  in  1  holds read issue while high.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle completion pulse.
- rd_en  out  1  2R1W read strobe, both ports.
- rd_addr_a  out  ADDR_W  2R1W port A address.
- rd_addr_b  out  ADDR_W  2R1W port B address.
- fe  out  1  first-element flag; high with the `rd_en` of element 0 only.
- wr_en  out  1  1R1W write enable.
- wr_addr  out  ADDR_W  1R1W write address.

Behaviour:
- Reset values:
  - State is IDLE.
  - Outputs are 0: `busy`, `done`, `rd_en`, `fe`, `wr_en`.
  - Address outputs are 0.
  - Element counter is 0.
  - All pipeline valid bits are 0.
- FSM: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On `start` = 1, latch `numberofv` into n and latch all three base addresses.
  - Go to ISSUE if n != 0; go to DONE if n == 0.
  - `start` is ignored in every other state; it is not queued.
- ISSUE, per cycle:
  - If `stall` = 0:
    - `rd_en` = 1.
    - `rd_addr_a` = src_a + idx and `rd_addr_b` = src_b + idx.
    - `fe` = (idx == 0).
    - Push {valid=1, dst + idx} into the latency pipe; then idx++.
  - If `stall` = 1:
    - `rd_en` and `fe` are 0, and idx is held.
    - Push {valid=0} into the latency pipe.
  - After the read with idx == n-1 is issued, go to DRAIN.
- Latency pipe:
  - RD_LAT stages that shift every cycle in all states, independent of `stall`.
  - The stage output drives `wr_en` and `wr_addr`.
  - Therefore `wr_en` follows each `rd_en` by exactly RD_LAT cycles, with `wr_addr` = dst + idx.
- DRAIN: when no pipe stage is valid, meaning the last `wr_en` has retired, go to DONE.
- DONE: `done` = 1 for exactly one cycle, then go to IDLE.
- `busy`: high in every non-IDLE state, including the DONE cycle. It is low in the cycle after `done`.
- Timing, no stall, `start` sampled at the edge ending cycle 0:
  - `rd_en` in cycles 1..n.
  - `wr_en` in cycles 1+RD_LAT..n+RD_LAT.
  - `done` in cycle n+RD_LAT+1.
- Timing, n == 0: `busy` and `done` both in cycle 1; no `rd_en` or `wr_en` ever.
- Address wrap: base + idx wraps modulo 2^ADDR_W silently, with no error.
- Maximum count: n = 2^CNT_W - 1 must issue exactly 255 reads (at default width). The counter must not overflow.
- Back-to-back commands: a `start` asserted in the `done` cycle is ignored. A `start` in the following IDLE cycle is accepted.
- Reset mid-operation:
  - Next cycle: IDLE with all outputs 0 and the pipe cleared.
  - In-flight writes are discarded; no `wr_en` follows the reset.
- Stall during DRAIN or IDLE: no effect.

Test Plan:
- Basic run: RD_LAT=2, n=4, src_a=0x010, src_b=0x100, dst=0x200.
  - `rd_en` cycles 1-4 with A=0x010..0x013 and B=0x100..0x103.
  - `fe` only in cycle 1.
  - `wr_en` cycles 3-6 with `wr_addr`=0x200..0x203.
  - `done` in cycle 7; `busy` cycles 1-7.
- Stall: n=3 with `stall` high in cycles 2-3.
  - `rd_en` in cycles 1, 4, 5 with idx 0, 1, 2.
  - `wr_en` in cycles 3, 6, 7.
  - `done` in cycle 8.
- Zero and maximum count:
  - n=0 gives `done` in cycle 1 with no enables.
  - n=255 gives exactly 255 `rd_en` and 255 `wr_en`, and `done` in cycle 258.
- Wrap: src_a=0x1FFE, n=4 → `rd_addr_a` = 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Reset mid-op: n=8, `reset` in cycle 5 → from cycle 6, `busy`, `rd_en` and `wr_en` are 0, with no `done`.
- Ignored `start`: `start` pulses during ISSUE and in the `done` cycle are ignored. A `start` in the cycle after `done` launches a new run with the new bases.
